// File: rtl/imem_arbiter.sv
// Two-way instruction-memory port arbiter: fetch (IF) has fixed priority, the
// loader (LD) is protected from starvation; each side has a one-entry response slot.
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  if_rsp_ready,
    input  logic                  ld_hold,
    input  logic                  ld_req_valid,
    input  logic                  ld_req_we,
    input  logic [ADDR_WIDTH-1:0] ld_req_addr,
    input  logic [DATA_WIDTH-1:0] ld_req_wdata,
    output logic                  ld_req_ready,
    output logic                  ld_rsp_valid,
    output logic [DATA_WIDTH-1:0] ld_rsp_data,
    input  logic                  ld_rsp_ready,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic                  if_elig, ld_elig, grant_if, grant_ld;
    logic                  if_rsp_valid_q, if_rsp_valid_d;
    logic [DATA_WIDTH-1:0] if_rsp_data_q, if_rsp_data_d;
    logic                  ld_rsp_valid_q, ld_rsp_valid_d;
    logic [DATA_WIDTH-1:0] ld_rsp_data_q, ld_rsp_data_d;
    logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_req_addr[1:0], ld_req_addr[1:0]};

    // Grants are gated by rst so nothing, in particular no write, reaches the RAM in reset.
    always_comb begin
        if_elig  = !rst && if_req_valid && !if_flush && !ld_hold &&
                   (!if_rsp_valid_q || if_rsp_ready);
        ld_elig  = !rst && ld_req_valid && (!ld_rsp_valid_q || ld_rsp_ready);
        grant_ld = ld_elig && (!if_elig || (starve_cnt_q >= LIMIT));
        grant_if = if_elig && !grant_ld;
    end

    always_comb begin
        if_rsp_valid_d = if_rsp_valid_q;
        if_rsp_data_d  = if_rsp_data_q;
        if (if_flush) begin
            if_rsp_valid_d = 1'b0;
        end else if (grant_if) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rdata;
        end else if (if_rsp_ready) begin
            if_rsp_valid_d = 1'b0;
        end

        ld_rsp_valid_d = ld_rsp_valid_q;
        ld_rsp_data_d  = ld_rsp_data_q;
        if (grant_ld) begin
            ld_rsp_valid_d = 1'b1;
            ld_rsp_data_d  = ld_req_we ? ld_req_wdata : mem_rdata;
        end else if (ld_rsp_ready) begin
            ld_rsp_valid_d = 1'b0;
        end

        // Counts consecutive cycles LD was eligible but lost to IF; saturates at the limit.
        starve_cnt_d = starve_cnt_q;
        if (grant_ld || !ld_req_valid) begin
            starve_cnt_d = '0;
        end else if (ld_elig && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ld_rsp_valid_q <= 1'b0;
            ld_rsp_data_q  <= '0;
            starve_cnt_q   <= '0;
        end else begin
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ld_rsp_valid_q <= ld_rsp_valid_d;
            ld_rsp_data_q  <= ld_rsp_data_d;
            starve_cnt_q   <= starve_cnt_d;
        end
    end

    always_comb begin
        if_req_ready = grant_if;
        ld_req_ready = grant_ld;
        mem_we       = grant_ld && ld_req_we;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!rst) begin
            mem_addr  = grant_ld ? ld_req_addr[ADDR_WIDTH-1:2] : if_req_addr[ADDR_WIDTH-1:2];
            mem_wdata = ld_req_wdata;
        end
        if_rsp_valid = !rst && if_rsp_valid_q;
        if_rsp_data  = rst ? '0 : if_rsp_data_q;
        ld_rsp_valid = !rst && ld_rsp_valid_q;
        ld_rsp_data  = rst ? '0 : ld_rsp_data_q;
    end
endmodule
